// File: rtl/reset_source_sequencer_pkg.sv
// ============================================================================
// Module  : reset_source_sequencer_pkg
// Brief   : Shared state encoding and helpers for the reset source sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif

package reset_source_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRE    = 3'd1,
      S_SWITCH = 3'd2,
      S_POST   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // Selector power-up value of the reset mux (B_RST).
   localparam logic C_SRC_POWERUP = 1'b0;

   function automatic bit fits_cnt(input int value, input int width);
      return (value >= 0) && (value <= ((2 ** width) - 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/reset_source_sequencer_down_counter.sv
// ============================================================================
// Module  : rst_seq_down_counter
// Brief   : Loadable hold counter with zero/one flags; saturates at zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq_down_counter #(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_value,
   input  logic             i_dec,
   output logic             o_zero,
   output logic             o_one
);

   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   logic [CNT_W-1:0] r_value;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_value;
      end else if (i_dec && (r_value != '0)) begin
         r_value <= r_value - c_one;
      end
   end

   assign o_zero = (r_value == '0);
   assign o_one  = (r_value == c_one);

endmodule

`default_nettype wire

// File: rtl/reset_source_sequencer.sv
// ============================================================================
// Module  : reset_source_sequencer
// Brief   : Drives reset-mux SELECT/SELECT_ENABLE with a forced reset window
//           around every source change.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_source_sequencer
   import reset_source_sequencer_pkg::*;
#(
   parameter int PRE_CYCLES  = 4,
   parameter int POST_CYCLES = 8,
   parameter int CNT_W       = 8
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic REQ_VALID,
   input  logic REQ_SEL,
   output logic REQ_READY,
   output logic SELECT,
   output logic SELECT_ENABLE,
   output logic FORCE_RST_N,
   output logic CUR_SEL,
   output logic BUSY,
   output logic DONE
);

   localparam logic [CNT_W-1:0] c_pre  = CNT_W'(PRE_CYCLES);
   localparam logic [CNT_W-1:0] c_post = CNT_W'(POST_CYCLES);

   generate
      if (!fits_cnt(PRE_CYCLES, CNT_W)) begin : g_bad_pre
         $error("PRE_CYCLES does not fit in CNT_W bits");
      end
      if (!fits_cnt(POST_CYCLES, CNT_W)) begin : g_bad_post
         $error("POST_CYCLES does not fit in CNT_W bits");
      end
   endgenerate

   state_t           r_state;
   logic             r_ready;
   logic             r_select;
   logic             r_sel_en;
   logic             r_force_n;
   logic             r_cur_sel;
   logic             r_busy;
   logic             r_done;

   logic             w_accept;
   logic             w_change;
   logic             w_load;
   logic [CNT_W-1:0] w_load_value;
   logic             w_dec;
   logic             w_cnt_zero;
   logic             w_cnt_one;
   logic             w_hold_last;

   assign w_accept    = r_ready && REQ_VALID;
   assign w_change    = (REQ_SEL != r_cur_sel);
   // Zero is included so a zero-length hold can never stall the sequence.
   assign w_hold_last = w_cnt_one || w_cnt_zero;

   always_comb begin
      w_load       = 1'b0;
      w_load_value = c_pre;
      w_dec        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_change) begin
               w_load       = 1'b1;
               w_load_value = c_pre;
            end
         end
         S_SWITCH: begin
            w_load       = 1'b1;
            w_load_value = c_post;
         end
         S_PRE, S_POST: begin
            w_dec = 1'b1;
         end
         default: begin
            w_dec = 1'b0;
         end
      endcase
   end

   rst_seq_down_counter #(
      .CNT_W (CNT_W)
   ) u_hold_cnt (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .i_load       (w_load),
      .i_load_value (w_load_value),
      .i_dec        (w_dec),
      .o_zero       (w_cnt_zero),
      .o_one        (w_cnt_one)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= S_IDLE;
         r_ready   <= 1'b1;
         r_select  <= C_SRC_POWERUP;
         r_sel_en  <= 1'b0;
         r_force_n <= 1'b1;
         r_cur_sel <= C_SRC_POWERUP;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_sel_en <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  if (w_change) begin
                     r_select  <= REQ_SEL;
                     r_force_n <= 1'b0;
                     if (PRE_CYCLES == 0) begin
                        r_state  <= S_SWITCH;
                        r_sel_en <= 1'b1;
                     end else begin
                        r_state <= S_PRE;
                     end
                  end else begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_PRE: begin
               if (w_hold_last) begin
                  r_state  <= S_SWITCH;
                  r_sel_en <= 1'b1;
               end
            end
            S_SWITCH: begin
               // The mux captures SELECT on this edge; keep the shadow in step.
               r_cur_sel <= r_select;
               if (POST_CYCLES == 0) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_force_n <= 1'b1;
               end else begin
                  r_state <= S_POST;
               end
            end
            S_POST: begin
               if (w_hold_last) begin
                  r_state   <= S_DONE;
                  r_done    <= 1'b1;
                  r_force_n <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_ready   <= 1'b1;
               r_force_n <= 1'b1;
            end
         endcase
      end
   end

   assign REQ_READY     = r_ready;
   assign SELECT        = r_select;
   assign SELECT_ENABLE = r_sel_en;
   assign FORCE_RST_N   = r_force_n;
   assign CUR_SEL       = r_cur_sel;
   assign BUSY          = r_busy;
   assign DONE          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reset_source_sequencer.sv
// ============================================================================
// Module  : tb_reset_source_sequencer
// Brief   : Self-checking bench for reset_source_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reset_source_sequencer;

   localparam int PRE  = 4;
   localparam int POST = 8;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;

   logic req_valid = 1'b0;
   logic req_sel   = 1'b0;
   logic req_ready, select_o, sel_en, force_n, cur_sel, busy, done;

   logic z_valid = 1'b0;
   logic z_sel   = 1'b0;
   logic z_ready, z_select, z_sel_en, z_force_n, z_cur_sel, z_busy, z_done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   reset_source_sequencer #(
      .PRE_CYCLES (PRE),
      .POST_CYCLES(POST),
      .CNT_W      (8)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .REQ_VALID    (req_valid),
      .REQ_SEL      (req_sel),
      .REQ_READY    (req_ready),
      .SELECT       (select_o),
      .SELECT_ENABLE(sel_en),
      .FORCE_RST_N  (force_n),
      .CUR_SEL      (cur_sel),
      .BUSY         (busy),
      .DONE         (done)
   );

   reset_source_sequencer #(
      .PRE_CYCLES (0),
      .POST_CYCLES(0),
      .CNT_W      (4)
   ) dut0 (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .REQ_VALID    (z_valid),
      .REQ_SEL      (z_sel),
      .REQ_READY    (z_ready),
      .SELECT       (z_select),
      .SELECT_ENABLE(z_sel_en),
      .FORCE_RST_N  (z_force_n),
      .CUR_SEL      (z_cur_sel),
      .BUSY         (z_busy),
      .DONE         (z_done)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is described by its cycle index k since accept.
   bit   m_active = 1'b0;
   int   m_k      = 0;
   bit   m_change = 1'b0;
   logic m_sel    = 1'b0;
   logic m_cur    = 1'b0;
   logic p_sel_en = 1'b0;
   logic p_done   = 1'b0;

   function automatic int done_k();
      return m_change ? (2 + PRE + POST) : 1;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_k      = 0;
      m_change = 1'b0;
      m_sel    = 1'b0;
      m_cur    = 1'b0;
      p_sel_en = 1'b0;
      p_done   = 1'b0;
   endtask

   task automatic model_edge();
      if (!RST_N) begin
         model_reset();
      end else if (!m_active) begin
         if (req_valid) begin
            m_active = 1'b1;
            m_k      = 1;
            m_change = (req_sel != m_cur);
            if (m_change) m_sel = req_sel;
         end
      end else begin
         m_k++;
         if (m_change && (m_k == 2 + PRE)) m_cur = m_sel;
         if (m_k > done_k()) m_active = 1'b0;
      end
   endtask

   task automatic model_check();
      logic e_f, e_e, e_d;
      e_f = !(m_active && m_change && (m_k <= 1 + PRE + POST));
      e_e = m_active && m_change && (m_k == 1 + PRE);
      e_d = m_active && (m_k == done_k());
      chk("mdl_force_n", force_n, e_f);
      chk("mdl_sel_en", sel_en, e_e);
      chk("mdl_done", done, e_d);
      chk("mdl_ready", req_ready, !m_active);
      chk("mdl_busy", busy, m_active);
      chk("mdl_select", select_o, m_sel);
      chk("mdl_cur_sel", cur_sel, m_cur);
      chk("prop_en_forces", sel_en & force_n, 1'b0);
      chk("prop_en_pulse", p_sel_en & sel_en, 1'b0);
      chk("prop_done_pulse", p_done & done, 1'b0);
      p_sel_en = sel_en;
      p_done   = done;
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      model_check();
   endtask

   // Called one time unit after an edge; asserts reset asynchronously mid-cycle.
   task automatic do_reset();
      req_valid = 1'b0;
      z_valid   = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      model_reset();
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_select", select_o, 1'b0);
      chk("rst_sel_en", sel_en, 1'b0);
      chk("rst_force_n", force_n, 1'b1);
      chk("rst_cur_sel", cur_sel, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_z_ready", z_ready, 1'b1);
      chk("rst_z_force_n", z_force_n, 1'b1);
      #2 RST_N = 1'b1;
   endtask

   typedef struct packed {
      logic v, s, f, e, sel, cur, d, r, b;
   } vec_t;

   vec_t vecs [15];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // Scenario 1 table: row i holds inputs for edge i and outputs for cycle i+1.
      for (int i = 0; i < 15; i++) begin
         vecs[i].v   = 1'b0;
         vecs[i].s   = 1'b0;
         vecs[i].f   = 1'b0;
         vecs[i].e   = 1'b0;
         vecs[i].sel = 1'b1;
         vecs[i].cur = (i >= 5);
         vecs[i].d   = 1'b0;
         vecs[i].r   = 1'b0;
         vecs[i].b   = 1'b1;
      end
      vecs[0].v  = 1'b1;
      vecs[0].s  = 1'b1;
      vecs[4].e  = 1'b1;
      vecs[13].f = 1'b1;
      vecs[13].d = 1'b1;
      vecs[14].f = 1'b1;
      vecs[14].r = 1'b1;
      vecs[14].b = 1'b0;

      @(posedge CLK);
      #1;
      do_reset();

      for (int i = 0; i < 15; i++) begin
         req_valid = vecs[i].v;
         req_sel   = vecs[i].s;
         tick();
         chk("s1_force_n", force_n, vecs[i].f);
         chk("s1_sel_en", sel_en, vecs[i].e);
         chk("s1_select", select_o, vecs[i].sel);
         chk("s1_cur_sel", cur_sel, vecs[i].cur);
         chk("s1_done", done, vecs[i].d);
         chk("s1_ready", req_ready, vecs[i].r);
         chk("s1_busy", busy, vecs[i].b);
      end

      // Scenario 2: same-source request.
      do_reset();
      req_valid = 1'b1;
      req_sel   = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("s2_done", done, 1'b1);
      chk("s2_force_n", force_n, 1'b1);
      chk("s2_sel_en", sel_en, 1'b0);
      chk("s2_ready", req_ready, 1'b0);
      tick();
      chk("s2_done_end", done, 1'b0);
      chk("s2_ready_back", req_ready, 1'b1);

      // Scenario 3: zero-length holds on the second instance.
      do_reset();
      z_valid = 1'b1;
      z_sel   = 1'b1;
      tick();
      z_valid = 1'b0;
      chk("s3_force_n_sw", z_force_n, 1'b0);
      chk("s3_sel_en_sw", z_sel_en, 1'b1);
      chk("s3_select", z_select, 1'b1);
      chk("s3_busy", z_busy, 1'b1);
      tick();
      chk("s3_done", z_done, 1'b1);
      chk("s3_force_n_done", z_force_n, 1'b1);
      chk("s3_sel_en_off", z_sel_en, 1'b0);
      chk("s3_cur_sel", z_cur_sel, 1'b1);
      tick();
      chk("s3_ready", z_ready, 1'b1);
      chk("s3_done_end", z_done, 1'b0);

      // Scenario 4: second request held while busy.
      do_reset();
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      req_valid = 1'b1;
      req_sel   = 1'b0;
      for (int c = 3; c < 15; c++) begin
         chk("s4_ignored_ready", req_ready, 1'b0);
         chk("s4_select_held", select_o, 1'b1);
         tick();
      end
      chk("s4_ready_rises", req_ready, 1'b1);
      tick();
      req_valid = 1'b0;
      chk("s4_accepted", busy, 1'b1);
      chk("s4_select_new", select_o, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (done) found = 1'b1;
         else tick();
      end
      chk("s4_done_seen", found, 1'b1);
      tick();
      chk("s4_cur_sel", cur_sel, 1'b0);

      // Scenario 5: async reset during POST.
      do_reset();
      req_valid = 1'b1;
      req_sel   = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("s5_in_post", force_n, 1'b0);
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("s5_no_sel_en", sel_en, 1'b0);
         chk("s5_force_n", force_n, 1'b1);
      end

      // Random requests against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_sel   = 1'($urandom_range(0, 1));
         if (i % 300 == 299) do_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
